// File: rtl/multi_hot_encoder_scanner_pkg.sv
// Package shared by the multi-hot encoder scanner slice.
// Holds the FSM state encoding and a ceiling-log2 helper used to size index
// ports. The helper exists for tools that lack a usable $clog2.
package multi_hot_encoder_scanner_pkg;

  // Scanner FSM states: waiting for a vector, or emitting its indices
  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  // Ceiling log2; returns the number of bits needed to index 'value' items
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/multi_hot_encoder_scanner_priority_index_encoder.sv
// Combinational priority index encoder (generalised 4-to-2 encoder).
// Ports:
//   req    in   WIDTH  request bits, any pattern
//   index  out  IDXW   index of the winning bit (0 when no bit is set)
//   any    out  1      at least one request bit is set
//   onehot out  WIDTH  the winning bit isolated (all zeros when none set)
// MSB_FIRST = 0 selects the lowest set bit, 1 selects the highest set bit.
module priority_index_encoder
  import multi_hot_encoder_scanner_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 0,
  parameter int IDXW      = clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] req,
  output logic [IDXW-1:0]  index,
  output logic             any,
  output logic [WIDTH-1:0] onehot
);

  // Scan all bits in the order where the preferred winner is visited last,
  // so its assignment is the one that sticks
  always_comb begin
    index  = {IDXW{1'b0}};
    any    = 1'b0;
    onehot = {WIDTH{1'b0}};
    for (int k = 0; k < WIDTH; k++) begin
      int pos;
      pos   = (MSB_FIRST != 0) ? k : (WIDTH - 1 - k);
      index = req[pos] ? IDXW'(pos) : index;
      any   = any | req[pos];
    end
    onehot = any ? ({{(WIDTH-1){1'b0}}, 1'b1} << index) : {WIDTH{1'b0}};
  end

endmodule

// File: rtl/multi_hot_encoder_scanner.sv
// Multi-hot encoder scanner.
// Captures a WIDTH-bit request vector over a valid/ready handshake, then emits
// the binary index of each set bit, one per output handshake, in priority
// order (lowest first, or highest first with MSB_FIRST=1).
// Ports:
//   Clk      in   1       rising-edge clock
//   Rst_n    in   1       synchronous active-low reset
//   W_valid  in   1       request vector valid
//   W_ready  out  1       scanner idle and able to capture
//   W        in   WIDTH   request vector
//   Y_valid  out  1       Y holds a valid index
//   Y_ready  in   1       consumer accepts Y
//   Y        out  IDXW    index of current set bit
//   last     out  1       Y is the final index of the captured vector
//   zero     out  1       one-cycle pulse: captured vector was all zeros
//   multi    out  1       captured vector had more than one bit set
//   count    out  IDXW+1  popcount of the captured vector
module multi_hot_encoder_scanner
  import multi_hot_encoder_scanner_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int IDXW      = clog2(WIDTH),
  parameter int MSB_FIRST = 0
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             W_valid,
  output logic             W_ready,
  input  logic [WIDTH-1:0] W,
  output logic             Y_valid,
  input  logic             Y_ready,
  output logic [IDXW-1:0]  Y,
  output logic             last,
  output logic             zero,
  output logic             multi,
  output logic [IDXW:0]    count
);

  state_e              state_r;
  logic [WIDTH-1:0]    pending_r;
  logic                zero_r;
  logic                multi_r;
  logic [IDXW:0]       count_r;

  logic [IDXW-1:0]     index_s;
  logic                any_s;
  logic [WIDTH-1:0]    onehot_s;
  logic [IDXW:0]       popcnt_s;

  function automatic logic [IDXW:0] popcount(input logic [WIDTH-1:0] v);
    logic [IDXW:0] c;
    c = {(IDXW+1){1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      c = c + {{IDXW{1'b0}}, v[i]};
    end
    return c;
  endfunction

  // Y and last both come from the pending register only, never from W
  priority_index_encoder #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST),
    .IDXW      (IDXW)
  ) u_pick (
    .req    (pending_r),
    .index  (index_s),
    .any    (any_s),
    .onehot (onehot_s)
  );

  assign popcnt_s = popcount(W);

  // Scanner FSM: capture in IDLE, retire one set bit per accepted Y in EMIT
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_r   <= IDLE;
      pending_r <= {WIDTH{1'b0}};
      zero_r    <= 1'b0;
      multi_r   <= 1'b0;
      count_r   <= {(IDXW+1){1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (W_valid) begin
            count_r <= popcnt_s;
            multi_r <= (popcnt_s > (IDXW+1)'(1));
            if (W == {WIDTH{1'b0}}) begin
              zero_r <= 1'b1;
            end else begin
              zero_r    <= 1'b0;
              pending_r <= W;
              state_r   <= EMIT;
            end
          end else begin
            zero_r <= 1'b0;
          end
        end
        EMIT: begin
          zero_r <= 1'b0;
          if (Y_ready) begin
            // Clearing the emitted bit drains pending to zero on the last one
            pending_r <= pending_r & ~onehot_s;
            if (last) begin
              state_r <= IDLE;
            end else begin
              state_r <= EMIT;
            end
          end else begin
            pending_r <= pending_r;
          end
        end
        default: begin
          state_r   <= IDLE;
          pending_r <= {WIDTH{1'b0}};
          zero_r    <= 1'b0;
        end
      endcase
    end
  end

  assign W_ready = (state_r == IDLE);
  assign Y_valid = (state_r == EMIT);
  assign Y       = index_s;
  // Exactly one bit set: removing the winner leaves nothing behind
  assign last    = (state_r == EMIT) && any_s &&
                   ((pending_r & ~onehot_s) == {WIDTH{1'b0}});
  assign zero    = zero_r;
  assign multi   = multi_r;
  assign count   = count_r;

endmodule

// File: tb/tb_multi_hot_encoder_scanner.sv
// Testbench: one LSB-first and one MSB-first scanner share all inputs.
// Expected (last, index) pairs are queued at capture time and popped as each
// output handshake occurs.
module tb_multi_hot_encoder_scanner;

  logic       clk;
  logic       rst_n;
  logic       w_valid;
  logic [7:0] w;
  logic       y_ready;

  logic       w_ready_l, y_valid_l, last_l, zero_l, multi_l;
  logic [2:0] y_l;
  logic [3:0] count_l;
  logic       w_ready_m, y_valid_m, last_m, zero_m, multi_m;
  logic [2:0] y_m;
  logic [3:0] count_m;

  int vectors     = 0;
  int miscompares = 0;

  logic [3:0] q_l[$];
  logic [3:0] q_m[$];

  multi_hot_encoder_scanner #(.WIDTH(8), .MSB_FIRST(0)) dut_lsb (
    .Clk(clk), .Rst_n(rst_n), .W_valid(w_valid), .W_ready(w_ready_l), .W(w),
    .Y_valid(y_valid_l), .Y_ready(y_ready), .Y(y_l), .last(last_l),
    .zero(zero_l), .multi(multi_l), .count(count_l)
  );

  multi_hot_encoder_scanner #(.WIDTH(8), .MSB_FIRST(1)) dut_msb (
    .Clk(clk), .Rst_n(rst_n), .W_valid(w_valid), .W_ready(w_ready_m), .W(w),
    .Y_valid(y_valid_m), .Y_ready(y_ready), .Y(y_m), .last(last_m),
    .zero(zero_m), .multi(multi_m), .count(count_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: compare every valid Y (held during stalls), pop on handshake
  always @(negedge clk) begin
    if (rst_n === 1'b1 && y_valid_l === 1'b1) begin
      if (q_l.size() == 0) begin
        check("lsb_unexpected_y", {61'd0, y_l}, 64'hDEAD);
      end else begin
        check("lsb_y", {61'd0, y_l}, {61'd0, q_l[0][2:0]});
        check("lsb_last", {63'd0, last_l}, {63'd0, q_l[0][3]});
        if (y_ready) void'(q_l.pop_front());
      end
    end
    if (rst_n === 1'b1 && y_valid_m === 1'b1) begin
      if (q_m.size() == 0) begin
        check("msb_unexpected_y", {61'd0, y_m}, 64'hDEAD);
      end else begin
        check("msb_y", {61'd0, y_m}, {61'd0, q_m[0][2:0]});
        check("msb_last", {63'd0, last_m}, {63'd0, q_m[0][3]});
        if (y_ready) void'(q_m.pop_front());
      end
    end
  end

  // Drive one capture cycle and queue the expected index sequences
  task automatic send(input logic [7:0] v);
    int lo, hi;
    lo = -1;
    hi = -1;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) begin
        if (lo < 0) lo = i;
        hi = i;
      end
    end
    for (int i = 0; i < 8; i++)
      if (v[i]) q_l.push_back({(i == hi) ? 1'b1 : 1'b0, 3'(i)});
    for (int i = 7; i >= 0; i--)
      if (v[i]) q_m.push_back({(i == lo) ? 1'b1 : 1'b0, 3'(i)});
    w       = v;
    w_valid = 1'b1;
    step();
    w_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int c;
    c = 0;
    while ((q_l.size() != 0 || q_m.size() != 0) && c < budget) begin
      step();
      c++;
    end
    check("drain_left", 64'(q_l.size() + q_m.size()), 64'd0);
    check("idle_ready_l", {63'd0, w_ready_l}, 64'd1);
    check("idle_ready_m", {63'd0, w_ready_m}, 64'd1);
    check("idle_yvalid_l", {63'd0, y_valid_l}, 64'd0);
  endtask

  initial begin
    int c;
    logic [3:0] pat;
    // Reset held two cycles while a full vector is offered
    rst_n = 1'b0; w_valid = 1'b1; w = 8'hFF; y_ready = 1'b1;
    step(); step();
    check("rst_w_ready", {63'd0, w_ready_l}, 64'd1);
    check("rst_y_valid", {63'd0, y_valid_l}, 64'd0);
    check("rst_zero", {63'd0, zero_l}, 64'd0);
    check("rst_count", {60'd0, count_l}, 64'd0);
    check("rst_multi", {63'd0, multi_l}, 64'd0);
    check("rst_y", {61'd0, y_l}, 64'd0);
    check("rst_last", {63'd0, last_l}, 64'd0);
    w_valid = 1'b0; rst_n = 1'b1;
    step();
    check("rst_no_capture", {63'd0, y_valid_l}, 64'd0);

    // One-hot vector
    send(8'b0000_0100);
    check("oh_y_valid", {63'd0, y_valid_l}, 64'd1);
    check("oh_w_ready", {63'd0, w_ready_l}, 64'd0);
    check("oh_count", {60'd0, count_l}, 64'd1);
    check("oh_multi", {63'd0, multi_l}, 64'd0);
    step();
    check("oh_back_idle", {63'd0, w_ready_l}, 64'd1);
    check("oh_y_valid_off", {63'd0, y_valid_l}, 64'd0);

    // Multi-hot vector, both priority orders
    send(8'b1010_0011);
    check("mh_count_l", {60'd0, count_l}, 64'd4);
    check("mh_multi_l", {63'd0, multi_l}, 64'd1);
    check("mh_count_m", {60'd0, count_m}, 64'd4);
    check("mh_multi_m", {63'd0, multi_m}, 64'd1);
    wait_drain(20);

    // All-zero vector
    send(8'h00);
    check("z_zero", {63'd0, zero_l}, 64'd1);
    check("z_y_valid", {63'd0, y_valid_l}, 64'd0);
    check("z_w_ready", {63'd0, w_ready_l}, 64'd1);
    check("z_count", {60'd0, count_l}, 64'd0);
    check("z_multi", {63'd0, multi_l}, 64'd0);
    step();
    check("z_pulse_end", {63'd0, zero_l}, 64'd0);
    check("z_still_idle", {63'd0, y_valid_l}, 64'd0);

    // Full vector under backpressure, with ignored W_valid pulses
    pat = 4'b1001;
    send(8'hFF);
    check("full_count", {60'd0, count_l}, 64'd8);
    c = 0;
    while (q_l.size() != 0 && c < 100) begin
      y_ready = pat[c % 4];
      w_valid = ((c % 3) == 0) ? 1'b1 : 1'b0;
      w       = 8'h55;
      if (y_valid_l === 1'b1) check("bp_w_ready", {63'd0, w_ready_l}, 64'd0);
      step();
      c++;
    end
    w_valid = 1'b0;
    y_ready = 1'b1;
    wait_drain(4);
    check("full_count_held", {60'd0, count_l}, 64'd8);

    // Reset in the middle of an emission
    send(8'hF0);
    step();
    step();
    rst_n = 1'b0;
    step();
    check("mrst_y_valid", {63'd0, y_valid_l}, 64'd0);
    check("mrst_w_ready", {63'd0, w_ready_l}, 64'd1);
    check("mrst_count", {60'd0, count_l}, 64'd0);
    check("mrst_last", {63'd0, last_l}, 64'd0);
    q_l.delete();
    q_m.delete();
    rst_n = 1'b1;
    step();
    send(8'h01);
    check("mrst_new_count", {60'd0, count_l}, 64'd1);
    wait_drain(6);

    // A few pseudo-random vectors
    for (int r = 0; r < 6; r++) begin
      logic [7:0] v;
      v = 8'($urandom_range(1, 255));
      send(v);
      wait_drain(12);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multi_hot_encoder_scanner.md
Name: multi_hot_encoder_scanner

Overview:
- Parametrised, sequential successor to the 4-to-2 one-hot encoder.
- Accepts a WIDTH-bit request vector through a valid/ready handshake and captures it.
- Emits the binary index of every set bit, one index per handshake, in priority order. The old encoder gave X on multi-hot input; this block handles any bit pattern.
- Sits between request-collecting logic (switch/button banks, interrupt lines) and a consumer that services one index at a time (display or arbiter stage).

Parameters:
- WIDTH, 8, number of request bits; legal range 2..64.
- IDXW, $clog2(WIDTH), index width; derived, do not override.
- MSB_FIRST, 0, 0 = emit lowest set index first; 1 = emit highest set index first.

Ports:
- Clk  input  1  rising-edge clock
- Rst_n  input  1  synchronous, active-low reset
- W_valid  input  1  request vector W is valid
- W_ready  output  1  block can capture a vector
- W  input  WIDTH  request vector; any bit pattern is legal
- Y_valid  output  1  Y holds a valid index
- Y_ready  input  1  consumer accepts Y this cycle
- Y  output  IDXW  binary index of the current set bit
- last  output  1  qualifies Y: this is the final index of the captured vector
- zero  output  1  one-cycle pulse: captured vector was all zeros
- multi  output  1  captured vector had more than one bit set; held until the next capture
- count  output  IDXW+1  popcount of the captured vector; held until the next capture

Behaviour:
- Reset (Rst_n low at a rising edge):
  - state = IDLE; pending = 0.
  - W_ready = 1, Y_valid = 0, Y = 0, last = 0, zero = 0, multi = 0, count = 0.
  - Reset wins over every other event, including mid-emission; any un-emitted bits are discarded.
- States: IDLE, EMIT.
- IDLE:
  - W_ready = 1, Y_valid = 0.
  - Capture occurs on the cycle with W_valid && W_ready.
  - Capture of W == 0: zero = 1 for exactly the next cycle; count = 0; multi = 0; stay in IDLE.
  - Capture of W != 0: pending <= W; count <= popcount(W); multi <= (popcount > 1); go to EMIT.
  - First Y_valid is the cycle after capture (latency 1).
- EMIT:
  - W_ready = 0, Y_valid = 1.
  - Y = index of the lowest set bit of pending (MSB_FIRST=0) or the highest set bit (MSB_FIRST=1).
  - Y is decoded from the pending register only; there is no combinational path from W to Y.
  - last = 1 when exactly one bit of pending is set.
  - On Y_valid && Y_ready: clear that bit in pending. If last was 1, go to IDLE (W_ready = 1 the following cycle).
  - Y_ready low: Y, last and pending are held stable indefinitely (stall).
- W is ignored while in EMIT; no capture occurs regardless of W_valid.
- Y_ready while in IDLE has no effect.
- Throughput: a vector with k set bits occupies k EMIT cycles plus 1 IDLE cycle before the next capture.
- Full vector (all WIDTH bits set): count = WIDTH, which fits in IDXW+1 bits.
- WIDTH not a power of two: Y never exceeds WIDTH-1.
- W bit order: bit 0 is index 0.

Decomposition:
- Shared package/header holds:
  - the state encoding constants (IDLE = 1'b0, EMIT = 1'b1);
  - a clog2 helper function for Verilog-2001 tools.
- One natural sub-module: priority_index_encoder (combinational, parameters WIDTH and MSB_FIRST).
  - Outputs: index, any, onehot.
  - Generalises the 4-to-2 encoder; reused for both Y and last generation.
- Popcount is an inline function; no separate module.

Test Plan (WIDTH=8 unless noted):
- Reset check: hold Rst_n=0 for 2 cycles with W_valid=1, W=8'hFF -> W_ready=1, Y_valid=0, zero=0, count=0, no capture.
- One-hot, MSB_FIRST=0: W=8'b0000_0100 with Y_ready=1 -> one cycle later Y=2, last=1, multi=0, count=1; back in IDLE the next cycle.
- Multi-hot, MSB_FIRST=0: W=8'b1010_0011 with Y_ready=1 -> Y sequence 0,1,5,7; last=1 only on 7; count=4, multi=1. Same vector with MSB_FIRST=1 -> Y sequence 7,5,1,0.
- Zero input: W=0 -> zero high for exactly one cycle, Y_valid stays 0, W_ready stays 1.
- Backpressure: W=8'hFF with Y_ready toggling 1,0,0,1,... -> Y holds its value during stall cycles; all eight indices 0..7 appear exactly once; W_valid pulses during EMIT are ignored.
- Reset mid-emission: W=8'hF0, Rst_n=0 after the second index is accepted -> next cycle Y_valid=0, pending=0; the following capture of W=8'h01 yields Y=0, last=1.
